// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key sequencer:
// FSM state encoding, key codes and ALU operation encodings.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER_A = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_PRELOAD = 3'd5
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [3:0] d;
    d = k - KEY_ADD;
    return d[1:0];
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Classifies a strobed key code into digit / operator / equals / clear.
// Outputs are combinational and already qualified by the key strobe.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic       i_valid,
  input  logic [3:0] i_code,
  output logic       o_digit,
  output logic       o_oper,
  output logic       o_equals,
  output logic       o_clear
);

  always_comb begin
    o_digit  = i_valid && (i_code < KEY_ADD);
    o_oper   = i_valid && (i_code >= KEY_ADD) && (i_code <= KEY_DIV);
    o_equals = i_valid && (i_code == KEY_EQ);
    o_clear  = i_valid && (i_code == KEY_CLR);
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: turns key strobes into operand-entry and ALU control pulses.
// Optional result chaining (operator key in SHOW) is enabled by defining CALC_SEQ_CHAIN_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  output logic [3:0] digits,
  output logic       new_number,
  output logic [1:0] digit_number,
  output logic       operand_sel,
  output logic       new_operation,
  output logic       clear_operands,
  output logic [1:0] alu_op,
  output logic       alu_start,
  output logic       busy,
  output logic       result_valid
);

  localparam logic [2:0] MAXC = 3'(MAX_DIGITS);

  logic w_is_digit, w_is_oper, w_is_eq, w_is_clr;

  calc_key_decode u_dec (
    .i_valid  (key_valid),
    .i_code   (key_code),
    .o_digit  (w_is_digit),
    .o_oper   (w_is_oper),
    .o_equals (w_is_eq),
    .o_clear  (w_is_clr)
  );

  state_t     r_state, w_state;
  logic [2:0] r_cnt, w_cnt;
  logic [3:0] r_digits, w_digits;
  logic [1:0] r_dnum, w_dnum;
  logic       r_sel, w_sel;
  logic [1:0] r_op, w_op;
  logic       r_new_num, w_new_num;
  logic       r_clr, w_clr;
  logic       r_start, w_start;
  logic       r_busy, w_busy;
  logic       r_rv, w_rv;
`ifdef CALC_SEQ_CHAIN_EN
  logic       r_new_op, w_new_op;
`endif

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_digits  = r_digits;
    w_dnum    = r_dnum;
    w_sel     = r_sel;
    w_op      = r_op;
    w_new_num = 1'b0;
    w_clr     = 1'b0;
    w_start   = 1'b0;
`ifdef CALC_SEQ_CHAIN_EN
    w_new_op  = 1'b0;
`endif
    // alu_done in EXEC outranks every key, clear included
    if (w_is_clr && !(r_state == ST_EXEC && alu_done)) begin
      w_state = ST_IDLE;
      w_cnt   = 3'd0;
      w_op    = OP_ADD;
      w_sel   = 1'b0;
      w_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_digit) begin
            w_new_num = 1'b1;
            w_digits  = key_code;
            w_dnum    = 2'd0;
            w_sel     = 1'b0;
            w_cnt     = 3'd1;
            w_state   = ST_ENTER_A;
          end
        end
        ST_ENTER_A: begin
          if (w_is_digit && (r_cnt < MAXC)) begin
            w_new_num = 1'b1;
            w_digits  = key_code;
            w_dnum    = r_cnt[1:0];
            w_cnt     = r_cnt + 3'd1;
          end else if (w_is_oper) begin
            w_op    = key_to_op(key_code);
            w_sel   = 1'b1;
            w_cnt   = 3'd0;
            w_state = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          w_sel = 1'b1;
          if (w_is_digit && (r_cnt < MAXC)) begin
            w_new_num = 1'b1;
            w_digits  = key_code;
            w_dnum    = r_cnt[1:0];
            w_cnt     = r_cnt + 3'd1;
          end else if (w_is_oper && (r_cnt == 3'd0)) begin
            w_op = key_to_op(key_code);
          end else if (w_is_eq && (r_cnt != 3'd0)) begin
            w_start = 1'b1;
            w_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (alu_done) w_state = ST_SHOW;
        end
        ST_SHOW: begin
          if (w_is_digit) begin
            w_clr    = 1'b1;
            w_digits = key_code;
            w_sel    = 1'b0;
            w_state  = ST_PRELOAD;
          end
`ifdef CALC_SEQ_CHAIN_EN
          else if (w_is_oper) begin
            w_new_op = 1'b1;
            w_sel    = 1'b0;
            w_op     = key_to_op(key_code);
            w_cnt    = 3'd0;
            w_state  = ST_ENTER_B;
          end
`endif
        end
        ST_PRELOAD: begin
          // digit captured in SHOW is shifted in now that operands are cleared
          w_new_num = 1'b1;
          w_dnum    = 2'd0;
          w_sel     = 1'b0;
          w_cnt     = 3'd1;
          w_state   = ST_ENTER_A;
        end
        default: w_state = ST_IDLE;
      endcase
    end
    w_busy = (w_state == ST_EXEC);
    w_rv   = (w_state == ST_SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_digits  <= 4'd0;
      r_dnum    <= 2'd0;
      r_sel     <= 1'b0;
      r_op      <= OP_ADD;
      r_new_num <= 1'b0;
      r_clr     <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_rv      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_digits  <= w_digits;
      r_dnum    <= w_dnum;
      r_sel     <= w_sel;
      r_op      <= w_op;
      r_new_num <= w_new_num;
      r_clr     <= w_clr;
      r_start   <= w_start;
      r_busy    <= w_busy;
      r_rv      <= w_rv;
    end
  end

`ifdef CALC_SEQ_CHAIN_EN
  always_ff @(posedge clk) begin
    if (!rst) r_new_op <= 1'b0;
    else      r_new_op <= w_new_op;
  end
  assign new_operation = r_new_op;
`else
  assign new_operation = 1'b0;
`endif

  assign digits         = r_digits;
  assign new_number     = r_new_num;
  assign digit_number   = r_dnum;
  assign operand_sel    = r_sel;
  assign clear_operands = r_clr;
  assign alu_op         = r_op;
  assign alu_start      = r_start;
  assign busy           = r_busy;
  assign result_valid   = r_rv;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected pulses are queued with their due cycle
// when keys are driven and compared as the DUT emits them.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       alu_done = 1'b0;
  logic [3:0] digits;
  logic       new_number;
  logic [1:0] digit_number;
  logic       operand_sel;
  logic       new_operation;
  logic       clear_operands;
  logic [1:0] alu_op;
  logic       alu_start;
  logic       busy;
  logic       result_valid;

  calc_sequencer #(.MAX_DIGITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .alu_done       (alu_done),
    .digits         (digits),
    .new_number     (new_number),
    .digit_number   (digit_number),
    .operand_sel    (operand_sel),
    .new_operation  (new_operation),
    .clear_operands (clear_operands),
    .alu_op         (alu_op),
    .alu_start      (alu_start),
    .busy           (busy),
    .result_valid   (result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q[$];

  localparam logic [3:0] K_NUM = 4'd1, K_CLR = 4'd2, K_START = 4'd3, K_NEWOP = 4'd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input int due, input logic [3:0] kind, input logic [3:0] d,
                                     input logic [1:0] n, input logic s, input logic [1:0] op);
    logic [31:0] r;
    logic [15:0] t;
    t = due[15:0];
    r = {t, kind, 12'h000};
    case (kind)
      K_NUM:   r[11:0] = {d, n, s, 5'b00000};
      K_START: r[1:0]  = op;
      K_NEWOP: r[2]    = s;
      default: ;
    endcase
    return r;
  endfunction

  task automatic obs_pulse(input logic [3:0] kind);
    logic [31:0] o;
    o = pk(cyc, kind, digits, digit_number, operand_sel, alu_op);
    if (q.size() == 0) chk("extra_pulse", o, 32'h0);
    else chk("pulse", o, q.pop_front());
  endtask

  always @(negedge clk) begin
    if (clear_operands) obs_pulse(K_CLR);
    if (new_number)     obs_pulse(K_NUM);
    if (alu_start)      obs_pulse(K_START);
    if (new_operation)  obs_pulse(K_NEWOP);
  end

  // all helpers start and end on a falling edge
  task automatic ev(input logic [3:0] kind, input logic [3:0] d, input logic [1:0] n,
                    input logic s, input logic [1:0] op, input int off);
    q.push_back(pk(cyc + off, kind, d, n, s, op));
  endtask

  task automatic exp_num(input logic [3:0] d, input logic [1:0] n, input logic s);
    ev(K_NUM, d, n, s, 2'd0, 1);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic done_pulse();
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    chk("reset_outputs", {17'd0, digits, new_number, digit_number, operand_sel, new_operation,
                          clear_operands, alu_op, alu_start, busy, result_valid}, 32'd0);
    rst = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // 1 2 + 3 = with alu_done three cycles after equals
    exp_num(4'd1, 2'd0, 1'b0); press(4'h1);
    exp_num(4'd2, 2'd1, 1'b0); press(4'h2);
    press(KEY_ADD);
    chk("sel_after_op", 32'(operand_sel), 32'd1);
    exp_num(4'd3, 2'd0, 1'b1); press(4'h3);
    ev(K_START, 4'd0, 2'd0, 1'b0, OP_ADD, 1); press(KEY_EQ);
    chk("busy_exec", 32'(busy), 32'd1);
    idle(2);
    done_pulse();
    chk("rv_after_done", 32'(result_valid), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("op_add", 32'(alu_op), 32'(OP_ADD));

    // digit in SHOW: clear, preload, key in PRELOAD dropped
    ev(K_CLR, 4'd0, 2'd0, 1'b0, 2'd0, 1);
    ev(K_NUM, 4'd8, 2'd0, 1'b0, 2'd0, 2);
    press(4'h8);
    press(4'h3);
    chk("sel_after_preload", 32'(operand_sel), 32'd0);
    exp_num(4'd4, 2'd1, 1'b0); press(4'h4);
    idle(1);

    // five digits: the fifth is ignored
    do_reset();
    exp_num(4'd9, 2'd0, 1'b0); press(4'h9);
    exp_num(4'd8, 2'd1, 1'b0); press(4'h8);
    exp_num(4'd7, 2'd2, 1'b0); press(4'h7);
    exp_num(4'd6, 2'd3, 1'b0); press(4'h6);
    press(4'h5);
    idle(2);
    chk("q_drained_maxdig", 32'(q.size()), 32'd0);

    // operator replaced while B is empty
    do_reset();
    exp_num(4'd4, 2'd0, 1'b0); press(4'h4);
    press(KEY_ADD);
    press(KEY_MUL);
    exp_num(4'd2, 2'd0, 1'b1); press(4'h2);
    ev(K_START, 4'd0, 2'd0, 1'b0, OP_MUL, 1); press(KEY_EQ);
    chk("op_mul", 32'(alu_op), 32'(OP_MUL));

    // clear in EXEC, then late alu_done is ignored
    ev(K_CLR, 4'd0, 2'd0, 1'b0, 2'd0, 1); press(KEY_CLR);
    done_pulse();
    idle(1);
    chk("rv_after_clear", 32'(result_valid), 32'd0);
    chk("busy_after_clear", 32'(busy), 32'd0);
    chk("op_after_clear", 32'(alu_op), 32'd0);
    press(KEY_SUB);
    press(KEY_EQ);
    exp_num(4'd7, 2'd0, 1'b0); press(4'h7);

    // alu_done coinciding with a key: key dropped
    press(KEY_ADD);
    exp_num(4'd2, 2'd0, 1'b1); press(4'h2);
    ev(K_START, 4'd0, 2'd0, 1'b0, OP_ADD, 1); press(KEY_EQ);
    alu_done = 1'b1;
    press(4'h5);
    alu_done = 1'b0;
    chk("rv_done_wins", 32'(result_valid), 32'd1);

    // operator key in SHOW
`ifdef CALC_SEQ_CHAIN_EN
    ev(K_NEWOP, 4'd0, 2'd0, 1'b0, 2'd0, 1); press(KEY_SUB);
    idle(1);
    chk("chain_op", 32'(alu_op), 32'(OP_SUB));
    chk("chain_sel", 32'(operand_sel), 32'd1);
    chk("chain_rv", 32'(result_valid), 32'd0);
`else
    press(KEY_SUB);
    idle(2);
    chk("nochain_rv", 32'(result_valid), 32'd1);
    chk("nochain_op", 32'(alu_op), 32'(OP_ADD));
`endif

    // reset mid ENTER_B with two digits
    do_reset();
    exp_num(4'd1, 2'd0, 1'b0); press(4'h1);
    press(KEY_ADD);
    exp_num(4'd2, 2'd0, 1'b1); press(4'h2);
    exp_num(4'd3, 2'd1, 1'b1); press(4'h3);
    press(KEY_DIV);
    chk("op_locked_cnt", 32'(alu_op), 32'(OP_ADD));
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    chk("mid_reset_outputs", {17'd0, digits, new_number, digit_number, operand_sel, new_operation,
                              clear_operands, alu_op, alu_start, busy, result_valid}, 32'd0);
    press(KEY_EQ);
    exp_num(4'd5, 2'd0, 1'b0); press(4'h5);
    idle(2);

    chk("q_drained_end", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
